// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a show-ahead TX FIFO: pops a word whenever the
// FIFO is non-empty and sends start, LSB-first data, optional parity and stop.
module uart_tx_fifo_drain #(
    parameter int data_width = 8,
    parameter int os_ticks   = 16,
    parameter int sb_ticks   = 16,
    parameter bit parity_en  = 1'b0,
    parameter bit parity_odd = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);
    localparam int MAX_TICKS = (os_ticks > sb_ticks) ? os_ticks : sb_ticks;
    localparam int CW = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam int BW = (data_width > 2) ? $clog2(data_width) : 1;
    localparam logic [CW-1:0] OS_LAST  = CW'(os_ticks - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(sb_ticks - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(data_width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_q;
    logic [data_width-1:0] sh_q;
    logic                  par_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    // The pop is the IDLE cycle itself, so the FIFO advances on the same edge
    // that latches the head word; gated by reset so nothing pops while held.
    assign fifo_rd      = reset && (state_q == IDLE) && !fifo_empty;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        sh_q    <= fifo_r_data;
                        par_q   <= (^fifo_r_data) ^ parity_odd;
                        cnt_q   <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= DATA;
                            tx_q    <= sh_q[0];
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q <= '0;
                            sh_q  <= sh_q >> 1;
                            if (bit_q == BIT_LAST) begin
                                if (parity_en) begin
                                    state_q <= PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                // tx follows the bit that becomes sh_q[0] after this shift
                                bit_q <= bit_q + BW'(1);
                                tx_q  <= sh_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q   <= '0;
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (cnt_q == SB_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART serial transmitter sitting directly downstream of the TX FIFO.
- Pops one word whenever the FIFO is non-empty, then serialises it onto the tx line: start bit, data LSB-first, optional parity, stop bit(s).
- Bit timing comes from an external oversampling tick (baud generator); one bit lasts os_ticks ticks.
- The FIFO presents r_data combinationally at its read address, so the word is valid whenever empty=0.

Parameters:
- data_width, 8, data bits per frame (5..9 legal).
- os_ticks, 16, s_tick pulses per bit.
- sb_ticks, 16, s_tick pulses in the stop period (16=1, 24=1.5, 32=2 stop bits at os_ticks=16).
- parity_en, 0, 1 inserts a parity bit after the data.
- parity_odd, 0, 0=even parity, 1=odd parity (ignored if parity_en=0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk pulse at os_ticks x baud rate.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_data  input  data_width  FIFO head word, valid when fifo_empty=0.
- fifo_rd  output  1  one-clk pop strobe to the FIFO.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done_tick  output  1  one-clk pulse at end of the stop period.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
  - tick counter, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously. The popped word is lost; no re-read.
- States: IDLE, START, DATA, PARITY, STOP. tx is registered from state/shift-register (glitch-free).
- IDLE:
  - tx=1.
  - On the first clk edge with fifo_empty=0: latch fifo_r_data into the shift register, compute the parity bit from it, assert fifo_rd for exactly that one cycle, clear the tick counter, go to START.
  - fifo_rd is never asserted in any other state and never while fifo_empty=1.
- START:
  - tx=0.
  - The tick counter increments on each s_tick.
  - When s_tick=1 and count=os_ticks-1: clear the counter and go to DATA with bit counter=0.
- DATA:
  - tx=shift_reg[0].
  - On s_tick with count=os_ticks-1: shift right and increment the bit counter.
  - After bit data_width-1: go to PARITY if parity_en=1, else go to STOP.
- PARITY:
  - tx = XOR of data bits (even), or its inverse (odd).
  - Lasts os_ticks ticks, then go to STOP.
- STOP:
  - tx=1 for sb_ticks ticks.
  - On the final tick: tx_done_tick=1 for one cycle, then go to IDLE.
- Latency: the first clk cycle after entering IDLE with fifo_empty=0 produces the pop.
  - Start-bit low is visible on tx the cycle after the pop.
  - Back-to-back frames: the gap between the stop period end and the next start bit is ≤2 clk cycles; no extra idle bit time.
- tx_busy=1 in every state except IDLE.
- s_tick arriving in IDLE is ignored; the tick counter only runs in START/DATA/PARITY/STOP.
- Counter widths: tick counter wide enough for max(os_ticks, sb_ticks)-1; bit counter wide enough for data_width-1. No wrap beyond the terminal value.
- FIFO going empty mid-frame has no effect; the current frame completes.
- A FIFO write in the same cycle as the pop is the FIFO's concern; this block only samples fifo_empty in IDLE.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 during s_tick activity, release; fifo_empty=1 for 100 ticks.
  - Required: tx=1, fifo_rd never asserted, tx_busy=0.
- Single frame, defaults:
  - Stimulus: FIFO holds 0xA5, s_tick every 4 clks.
  - Required: exactly one fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks (64 clks); tx_done_tick pulses once; tx_busy falls afterwards.
- Back-to-back:
  - Stimulus: FIFO holds 0x00, 0xFF, 0x3C.
  - Required: three pops, three frames, no idle bit between frames, words in order, fifo_empty=1 at the end.
- Parity:
  - Stimulus: parity_en=1, parity_odd=0, data 0x07.
  - Required: parity bit 1.
  - Stimulus: parity_odd=1, data 0x07.
  - Required: parity bit 0.
  - Both cases: stop bit follows.
- Two stop bits:
  - Stimulus: sb_ticks=32.
  - Required: stop high for 32 ticks before the next start bit.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3.
  - Required: tx=1 and tx_busy=0 immediately (asynchronously).
  - After release with the FIFO non-empty: the next word is popped and sent from its start bit.
